// File: rtl/muldiv_seq_ctrl_if.sv
// Request/response bundle between the EX stage and the multiply/divide sequencer.
interface muldiv_seq_ctrl_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            flush;
    logic            busy;
    logic            stall;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, op, rs1, rs2, flush,
        input  busy, stall, done, result
    );

    modport slave (
        input  start, op, rs1, rs2, flush,
        output busy, stall, done, result
    );
endinterface

// File: rtl/muldiv_seq_ctrl.sv
// Iterative RV32M sequencer: radix-2 shift-add multiply and restoring divide, one bit per cycle.
// Optional signed operation is enabled by defining MULDIV_SIGNED_EN.
module muldiv_seq_ctrl #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN)
) (
    input logic              clk,
    input logic              rst,
    muldiv_seq_ctrl_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t          r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]      r_op;
    logic [XLEN-1:0] r_opnd, r_acc, r_lo, r_result;
    logic            w_accept, w_divz, w_last;
    logic [XLEN-1:0] w_a_abs, w_b_abs;
    logic [XLEN:0]   w_mul_sum, w_rem_sh, w_diff;
    logic [XLEN-1:0] w_acc_nxt, w_lo_nxt, w_raw, w_final;

`ifdef MULDIV_SIGNED_EN
    localparam int PW = 2 * XLEN;
    logic r_neg, w_neg, w_a_sgn, w_b_sgn, w_a_neg, w_b_neg;

    function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] x);
        return ~x + XLEN'(1);
    endfunction

    function automatic logic [XLEN-1:0] negate_hi(input logic [PW-1:0] p);
        logic [PW-1:0] n;
        n = ~p + PW'(1);
        return n[PW-1:XLEN];
    endfunction
`endif

    assign w_accept = (r_state == S_IDLE) && bus.start && !bus.flush;
    assign w_divz   = bus.op[2] && (bus.rs2 == '0);
    assign w_last   = (r_state == S_CALC) && (r_cnt == '0) && !bus.flush;

    // Operand conditioning: the core loop only ever sees magnitudes.
    always_comb begin
        w_a_abs = bus.rs1;
        w_b_abs = bus.rs2;
`ifdef MULDIV_SIGNED_EN
        w_a_sgn = bus.op[2] ? ~bus.op[0] : (bus.op[1:0] == 2'b01 || bus.op[1:0] == 2'b10);
        w_b_sgn = bus.op[2] ? ~bus.op[0] : (bus.op[1:0] == 2'b01);
        w_a_neg = w_a_sgn & bus.rs1[XLEN-1];
        w_b_neg = w_b_sgn & bus.rs2[XLEN-1];
        if (w_a_neg) w_a_abs = negate(bus.rs1);
        if (w_b_neg) w_b_abs = negate(bus.rs2);
        // Remainder follows the dividend; everything else follows the operand sign product.
        w_neg = (bus.op[2] && bus.op[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);
`endif
    end

    always_comb begin
        w_mul_sum = {1'b0, r_acc} + {1'b0, (r_lo[0] ? r_opnd : '0)};
        w_rem_sh  = {r_acc, r_lo[XLEN-1]};
        w_diff    = w_rem_sh - {1'b0, r_opnd};
        if (r_op[2]) begin
            if (!w_diff[XLEN]) begin
                w_acc_nxt = w_diff[XLEN-1:0];
                w_lo_nxt  = {r_lo[XLEN-2:0], 1'b1};
            end else begin
                w_acc_nxt = w_rem_sh[XLEN-1:0];
                w_lo_nxt  = {r_lo[XLEN-2:0], 1'b0};
            end
        end else begin
            w_acc_nxt = w_mul_sum[XLEN:1];
            w_lo_nxt  = {w_mul_sum[0], r_lo[XLEN-1:1]};
        end

        if (!r_op[2]) w_raw = (r_op[1:0] == 2'b00) ? w_lo_nxt : w_acc_nxt;
        else          w_raw = r_op[1] ? w_acc_nxt : w_lo_nxt;

        w_final = w_raw;
`ifdef MULDIV_SIGNED_EN
        if (r_neg) w_final = r_op[2] ? negate(w_raw) : negate_hi({w_acc_nxt, w_lo_nxt});
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        bus.busy    = 1'b0;
        bus.stall   = 1'b0;
        bus.done    = 1'b0;
        case (r_state)
            S_IDLE: begin
                bus.stall = bus.start;
                if (bus.start && !bus.flush) w_state_nxt = w_divz ? S_DONE : S_CALC;
            end
            S_CALC: begin
                bus.busy  = 1'b1;
                bus.stall = 1'b1;
                if (bus.flush)         w_state_nxt = S_IDLE;
                else if (r_cnt == '0)  w_state_nxt = S_DONE;
            end
            S_DONE: begin
                bus.busy    = 1'b1;
                bus.done    = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // r_lo holds the multiplier (then product low half) or the dividend (then quotient).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op     <= '0;
            r_opnd   <= '0;
            r_acc    <= '0;
            r_lo     <= '0;
            r_cnt    <= '0;
            r_result <= '0;
`ifdef MULDIV_SIGNED_EN
            r_neg    <= 1'b0;
`endif
        end else if (w_accept) begin
            r_op   <= bus.op;
            r_acc  <= '0;
            r_cnt  <= CNT_W'(XLEN - 1);
            r_opnd <= bus.op[2] ? w_b_abs : w_a_abs;
            r_lo   <= bus.op[2] ? w_a_abs : w_b_abs;
`ifdef MULDIV_SIGNED_EN
            r_neg  <= w_neg;
`endif
            if (w_divz) r_result <= bus.op[1] ? bus.rs1 : '1;
        end else if (r_state == S_CALC) begin
            r_acc <= w_acc_nxt;
            r_lo  <= w_lo_nxt;
            if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
            if (w_last) r_result <= w_final;
        end
    end

    assign bus.result = r_result;
endmodule

// File: tb/tb_muldiv_seq_ctrl.sv
// Self-checking bench for muldiv_seq_ctrl: vector table through a result scoreboard plus flush/reset sequences.
module tb_muldiv_seq_ctrl;
    localparam int XLEN = 32;
    localparam int NV   = 22;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        int          due;
    } sb_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   nchecks = 0;
    int   nerr = 0;
    sb_t  sb_q[$];
    vec_t vt[0:NV-1];

    muldiv_seq_ctrl_if #(.XLEN(XLEN)) bus();

    muldiv_seq_ctrl #(.XLEN(XLEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard side: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (!rst && bus.done === 1'b1) begin
            if (sb_q.size() == 0) begin
                nchecks++;
                nerr++;
                $display("FAIL unexpected_done: done=1 at cycle %0d with no request outstanding", cyc);
            end else begin
                sb_t e;
                e = sb_q.pop_front();
                chk("result", bus.result, e.res);
                chk("done_cycle", cyc, e.due);
            end
        end
    end

    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat);
        int  n_busy;
        int  n_stall;
        bit  seen;
        sb_t e;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.rs1   = a;
        bus.rs2   = b;
        #1;
        n_stall = (bus.stall === 1'b1) ? 1 : 0;
        n_busy  = (bus.busy === 1'b1) ? 1 : 0;
        e.res = exp;
        e.due = cyc + lat;
        sb_q.push_back(e);
        seen = 1'b0;
        for (int k = 1; k <= 40 && !seen; k++) begin
            @(negedge clk);
            if (bus.busy === 1'b1)  n_busy++;
            if (bus.stall === 1'b1) n_stall++;
            if (bus.done === 1'b1) begin
                seen = 1'b1;
            end else begin
                if (k == 1) begin
                    bus.start = 1'b0;
                    bus.op    = 3'($urandom_range(0, 7));
                    bus.rs1   = $urandom;
                    bus.rs2   = $urandom;
                end
                if (k == 5) bus.start = 1'b1;
                if (k == 6) bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;
        if (!seen) begin
            nchecks++;
            nerr++;
            $display("FAIL %s_timeout: no done within 40 cycles, required one", name);
            void'(sb_q.pop_back());
        end
        chk({name, "_busy_cycles"}, n_busy, lat);
        chk({name, "_stall_cycles"}, n_stall, lat);
        @(negedge clk);
        chk({name, "_done_single"}, {31'b0, bus.done}, 32'h0);
    endtask

    initial begin
        logic [31:0] prev;
        int          ndone;

        vt[0]  = '{3'b000, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE, 33};
        vt[1]  = '{3'b011, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 33};
        vt[2]  = '{3'b101, 32'd100,       32'd7,         32'd14,        33};
        vt[3]  = '{3'b111, 32'd100,       32'd7,         32'd2,         33};
        vt[4]  = '{3'b101, 32'h0000_1234, 32'h0,         32'hFFFF_FFFF, 1};
        vt[5]  = '{3'b111, 32'h0000_1234, 32'h0,         32'h0000_1234, 1};
        vt[6]  = '{3'b100, 32'h0000_1234, 32'h0,         32'hFFFF_FFFF, 1};
        vt[7]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
        vt[8]  = '{3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33};
        vt[9]  = '{3'b000, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 33};
        vt[10] = '{3'b011, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 33};
        vt[11] = '{3'b101, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 33};
        vt[12] = '{3'b111, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 33};
        vt[13] = '{3'b101, 32'd5,         32'd7,         32'd0,         33};
        vt[14] = '{3'b111, 32'd5,         32'd7,         32'd5,         33};
`ifdef MULDIV_SIGNED_EN
        vt[15] = '{3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33};
        vt[16] = '{3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33};
        vt[17] = '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33};
        vt[18] = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33};
        vt[19] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 33};
        vt[20] = '{3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 33};
`else
        vt[15] = '{3'b100, 32'hFFFF_FFF9, 32'd2,         32'h7FFF_FFFC, 33};
        vt[16] = '{3'b110, 32'hFFFF_FFF9, 32'd2,         32'h0000_0001, 33};
        vt[17] = '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
        vt[18] = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 33};
        vt[19] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33};
        vt[20] = '{3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 33};
`endif
        vt[21] = '{3'b101, 32'd1000,      32'd10,        32'd100,       33};

        bus.start = 1'b0;
        bus.op    = 3'b000;
        bus.rs1   = '0;
        bus.rs2   = '0;
        bus.flush = 1'b0;

        repeat (3) @(negedge clk);
        chk("reset_busy", {31'b0, bus.busy}, 32'h0);
        chk("reset_done", {31'b0, bus.done}, 32'h0);
        chk("reset_stall", {31'b0, bus.stall}, 32'h0);
        chk("reset_result", bus.result, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < NV; i++)
            run_op($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b, vt[i].exp, vt[i].lat);
        prev = vt[NV-1].exp;

        // Flush at cycle 10 of a MUL: back to IDLE next cycle, result untouched, no done.
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 3'b000;
        bus.rs1   = 32'hFFFF_FFFF;
        bus.rs2   = 32'h2;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (k == 10) bus.flush = 1'b1;
        end
        @(negedge clk);
        bus.flush = 1'b0;
        chk("flush_busy", {31'b0, bus.busy}, 32'h0);
        chk("flush_result", bus.result, prev);
        ndone = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.done === 1'b1) ndone++;
        end
        chk("flush_no_done", ndone, 0);

        // Flush together with start in IDLE: nothing accepted.
        bus.start = 1'b1;
        bus.flush = 1'b1;
        bus.op    = 3'b011;
        @(negedge clk);
        bus.start = 1'b0;
        bus.flush = 1'b0;
        chk("flush_start_busy", {31'b0, bus.busy}, 32'h0);
        chk("flush_start_result", bus.result, prev);

        // Asynchronous reset in the middle of CALC.
        bus.start = 1'b1;
        bus.op    = 3'b101;
        bus.rs1   = 32'd100;
        bus.rs2   = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_reset_busy", {31'b0, bus.busy}, 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", {31'b0, bus.busy}, 32'h0);
        chk("arst_stall", {31'b0, bus.stall}, 32'h0);
        chk("arst_done", {31'b0, bus.done}, 32'h0);
        chk("arst_result", bus.result, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        run_op("after_reset", 3'b101, 32'd100, 32'd7, 32'd14, 33);
        run_op("back_to_back", 3'b111, 32'd100, 32'd7, 32'd2, 33);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1);
    end
endmodule
